rename_stage: RTL and testbench

Register-rename stage directly upstream of the issue queue. It maps decoded architectural sources and destination onto the 64-entry physical register file and allocates a free physical register for each destination. It tracks per-physical-register readiness from the execute and memory broadcasts and presents each renamed instruction to issue as `rename_enque` / `rename_instr_num` / `rename_issueinfo` / `busy`. On FLUSH it restores the speculative map from the retirement map.

---
 rtl/rename_stage.sv | 118 +++++++++++
 tb/tb_rename_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rename_stage.sv
// rename_stage: maps 32 arch regs onto 64 phys regs, allocates destinations, tracks readiness, restores on FLUSH.
// Define RENAME_STATS_EN to build the stall-cycle and instruction-count statistics counters.
module rename_stage (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         STALL,
  input  logic         FLUSH,
  input  logic         dec_valid,
  input  logic [4:0]   dec_rs,
  input  logic [4:0]   dec_rt,
  input  logic [4:0]   dec_rd,
  input  logic         dec_wr,
  input  logic [151:0] dec_payload,
  input  logic         issue_halt,
  input  logic         exe_broadcast,
  input  logic [5:0]   exe_broadcast_map,
  input  logic         mem_broadcast,
  input  logic [5:0]   mem_broadcast_map,
  input  logic         rob_retire,
  input  logic [4:0]   rob_retire_arch,
  input  logic [5:0]   rob_retire_map,
  input  logic [5:0]   rob_retire_old_map,
  output logic         rename_enque,
  output logic [31:0]  rename_instr_num,
  output logic [169:0] rename_issueinfo,
  output logic [5:0]   rename_old_map,
  output logic [63:0]  busy,
  output logic         halt_decode,
  output logic [31:0]  rename_stall_cycles,
  output logic [31:0]  rename_instr_count
);
  logic [5:0]  spec_map_q [32];
  logic [5:0]  ret_map_q [32];
  logic [5:0]  ret_map_d [32];
  logic [63:0] free_q, free_d, ready_q, ready_d, bcast, refd;
  logic [31:0] cnt_q;
  logic [5:0]  alloc_idx, map_a, map_b, map_wr, old_map;
  logic        need_alloc, accept, alloc, ret_we;
  assign need_alloc  = dec_wr & (dec_rd != 5'd0);
  assign accept      = dec_valid & ~STALL & ~FLUSH & ~issue_halt & ((|free_q) | ~need_alloc);
  assign alloc       = accept & need_alloc;
  assign halt_decode = dec_valid & ~accept;
  assign ret_we      = rob_retire & (rob_retire_arch != 5'd0);
  assign map_a       = spec_map_q[dec_rs];
  assign map_b       = spec_map_q[dec_rt];
  assign map_wr      = alloc ? alloc_idx : 6'd0;
  assign old_map     = alloc ? spec_map_q[dec_rd] : 6'd0;
  assign bcast       = (exe_broadcast ? 64'd1 << exe_broadcast_map : 64'd0) |
                       (mem_broadcast ? 64'd1 << mem_broadcast_map : 64'd0);
  // Bypass same-cycle broadcasts so issue never misses a wakeup
  assign busy        = ready_q | bcast;
  always_comb begin
    alloc_idx = 6'd0;
    for (int i = 63; i > 0; i--) alloc_idx = free_q[i] ? 6'(i) : alloc_idx;
  end
  always_comb begin
    ret_map_d = ret_map_q;
    if (ret_we) ret_map_d[rob_retire_arch] = rob_retire_map;
    refd = 64'd1;
    for (int i = 1; i < 32; i++) refd[ret_map_d[i]] = 1'b1;
  end
  always_comb begin
    free_d  = free_q;
    ready_d = ready_q | bcast;
    if (alloc) begin
      free_d[alloc_idx]  = 1'b0;
      ready_d[alloc_idx] = 1'b0;
    end
    if (ret_we) free_d[rob_retire_old_map] = 1'b1;
    free_d[0]  = 1'b0;
    ready_d[0] = 1'b1;
    free_d  = FLUSH ? ~refd : free_d;
    ready_d = FLUSH ? '1 : ready_d;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 32; i++) begin
        spec_map_q[i] <= 6'(i);
        ret_map_q[i]  <= 6'(i);
      end
      free_q           <= {32'hFFFF_FFFF, 32'h0};
      ready_q          <= '1;
      cnt_q            <= 32'd1;
      rename_enque     <= 1'b0;
      rename_instr_num <= '0;
      rename_issueinfo <= '0;
      rename_old_map   <= '0;
    end else begin
      ret_map_q <= ret_map_d;
      free_q    <= free_d;
      ready_q   <= ready_d;
      if (FLUSH) spec_map_q <= ret_map_d;
      else if (alloc) spec_map_q[dec_rd] <= alloc_idx;
      if (accept) cnt_q <= cnt_q + 32'd1;
      rename_enque     <= accept;
      rename_instr_num <= accept ? cnt_q : '0;
      rename_issueinfo <= accept ? {dec_payload, map_wr, map_b, map_a} : '0;
      rename_old_map   <= old_map;
    end
  end
`ifdef RENAME_STATS_EN
  logic [31:0] stall_q, instr_q;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stall_q <= '0;
      instr_q <= '0;
    end else begin
      stall_q <= stall_q + 32'(halt_decode);
      instr_q <= instr_q + 32'(accept);
    end
  end
  assign rename_stall_cycles = stall_q;
  assign rename_instr_count  = instr_q;
`else
  assign rename_stall_cycles = '0;
  assign rename_instr_count  = '0;
`endif
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: randomized + directed bench; a queue-based reference model feeds a scoreboard checked by a monitor.
module tb_rename_stage;
  logic         CLK = 1'b0;
  logic         RESET, STALL, FLUSH, dec_valid, dec_wr, issue_halt;
  logic [4:0]   dec_rs, dec_rt, dec_rd, rob_retire_arch;
  logic [151:0] dec_payload;
  logic         exe_broadcast, mem_broadcast, rob_retire;
  logic [5:0]   exe_broadcast_map, mem_broadcast_map, rob_retire_map, rob_retire_old_map;
  logic         rename_enque, halt_decode;
  logic [31:0]  rename_instr_num, rename_stall_cycles, rename_instr_count;
  logic [169:0] rename_issueinfo;
  logic [5:0]   rename_old_map;
  logic [63:0]  busy;

  always #5 CLK = ~CLK;

  rename_stage dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH), .dec_valid(dec_valid),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd), .dec_wr(dec_wr), .dec_payload(dec_payload),
    .issue_halt(issue_halt), .exe_broadcast(exe_broadcast), .exe_broadcast_map(exe_broadcast_map),
    .mem_broadcast(mem_broadcast), .mem_broadcast_map(mem_broadcast_map), .rob_retire(rob_retire),
    .rob_retire_arch(rob_retire_arch), .rob_retire_map(rob_retire_map),
    .rob_retire_old_map(rob_retire_old_map), .rename_enque(rename_enque),
    .rename_instr_num(rename_instr_num), .rename_issueinfo(rename_issueinfo),
    .rename_old_map(rename_old_map), .busy(busy), .halt_decode(halt_decode),
    .rename_stall_cycles(rename_stall_cycles), .rename_instr_count(rename_instr_count)
  );

  typedef struct { logic [31:0] num; logic [169:0] info; logic [5:0] old; } exp_t;
  typedef struct { logic [4:0] arch; logic [5:0] nmap; logic [5:0] omap; } rob_t;
  exp_t sb[$];
  rob_t rob[$];
  int errs = 0, checks = 0;
  logic [5:0]  m_spec [32];
  logic [5:0]  m_ret [32];
  bit          m_free [64];
  bit          m_ready [64];
  logic [31:0] m_cnt, m_stall, m_instr;

  task automatic chk(input string name, input logic [169:0] act, input logic [169:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void mreset();
    for (int i = 0; i < 32; i++) begin m_spec[i] = 6'(i); m_ret[i] = 6'(i); end
    for (int i = 0; i < 64; i++) begin m_free[i] = (i >= 32); m_ready[i] = 1'b1; end
    m_cnt = 1; m_stall = 0; m_instr = 0;
    sb.delete();
    rob.delete();
  endfunction

  always @(posedge CLK) begin : monitor
    exp_t e;
    #1;
    if (RESET && rename_enque) begin
      if (sb.size() == 0) chk("unexpected_enque", 1'b1, 1'b0);
      else begin
        e = sb.pop_front();
        chk("instr_num", rename_instr_num, e.num);
        chk("issueinfo", rename_issueinfo, e.info);
        chk("old_map", rename_old_map, e.old);
      end
    end
  end

  task automatic step(input bit v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input bit wr, input bit st, input bit fl, input bit ih, input bit eb,
                      input logic [5:0] em, input bit mb, input logic [5:0] mm, input bit ret);
    bit acc, na, rw;
    int idx;
    rob_t r;
    exp_t e;
    bit used [64];
    logic [63:0] eb_v;
    logic [151:0] pl;
    @(negedge CLK);
    pl = 152'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    rw = ret && rob.size() > 0;
    r = rw ? rob[0] : '{5'd0, 6'd0, 6'd0};
    dec_valid = v; dec_rs = rs; dec_rt = rt; dec_rd = rd; dec_wr = wr; dec_payload = pl;
    STALL = st; FLUSH = fl; issue_halt = ih;
    exe_broadcast = eb; exe_broadcast_map = em; mem_broadcast = mb; mem_broadcast_map = mm;
    rob_retire = rw; rob_retire_arch = r.arch; rob_retire_map = r.nmap; rob_retire_old_map = r.omap;
    #1;
    na = wr && rd != 0;
    idx = -1;
    for (int i = 0; i < 64; i++) if (m_free[i] && idx < 0) idx = i;
    acc = v && !st && !fl && !ih && (idx >= 0 || !na);
    for (int i = 0; i < 64; i++) eb_v[i] = m_ready[i] || (eb && em == i) || (mb && mm == i);
    chk("halt_decode", halt_decode, v && !acc);
    chk("busy", busy, eb_v);
    if (acc) begin
      e.num = m_cnt;
      e.old = na ? m_spec[rd] : 6'd0;
      e.info = {pl, na ? 6'(idx) : 6'd0, m_spec[rt], m_spec[rs]};
      sb.push_back(e);
      m_cnt++; m_instr++;
    end
    if (v && !acc) m_stall++;
    if (eb && em != 0) m_ready[em] = 1'b1;
    if (mb && mm != 0) m_ready[mm] = 1'b1;
    if (acc && na) begin
      m_free[idx] = 1'b0; m_ready[idx] = 1'b0;
      rob.push_back('{rd, 6'(idx), e.old});
      m_spec[rd] = 6'(idx);
    end
    if (rw) begin
      void'(rob.pop_front());
      m_ret[r.arch] = r.nmap;
      m_free[r.omap] = 1'b1;
    end
    if (fl) begin
      m_spec = m_ret;
      for (int i = 0; i < 64; i++) used[i] = 1'b0;
      for (int a = 0; a < 32; a++) used[m_ret[a]] = 1'b1;
      for (int i = 0; i < 64; i++) begin m_free[i] = i != 0 && !used[i]; m_ready[i] = 1'b1; end
      rob.delete();
    end
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input bit wr);
    step(1, rs, rt, rd, wr, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input bit ret, input bit fl);
    step(0, 0, 0, 0, 0, 0, fl, 0, 0, 0, 0, 0, ret);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 0; STALL = 0; FLUSH = 0; dec_valid = 0; dec_wr = 0; issue_halt = 0;
    dec_rs = 0; dec_rt = 0; dec_rd = 0; dec_payload = '0;
    exe_broadcast = 0; mem_broadcast = 0; exe_broadcast_map = 0; mem_broadcast_map = 0;
    rob_retire = 0; rob_retire_arch = 0; rob_retire_map = 0; rob_retire_old_map = 0;
    mreset();
    @(negedge CLK);
    RESET = 1;
  endtask

  initial begin
    int q[$];
    logic [5:0] em, mm;
    do_reset();
    chk("rst_enque", rename_enque, 0);
    chk("rst_num", rename_instr_num, 0);
    chk("rst_info", rename_issueinfo, 0);
    chk("rst_busy", busy, {64{1'b1}});
    // add r3,r1,r2 then sub r4,r3,r3 with exe wakeup of 32
    instr(1, 2, 3, 1);
    step(1, 3, 3, 4, 1, 0, 0, 0, 1, 6'd32, 0, 0, 0);
    chk("bypass_busy32", busy[32], 1);
    chk("first_maps", rename_issueinfo[17:0], {6'd32, 6'd2, 6'd1});
    chk("first_old", rename_old_map, 3);
    chk("first_num", rename_instr_num, 1);
    for (int k = 0; k < 30; k++) instr(5'($urandom_range(31)), 5'($urandom_range(31)), 5'(1 + k % 31), 1);
    instr(1, 2, 7, 1);
    chk("full_halt", halt_decode, 1);
    step(1, 1, 2, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("freed_not_yet", halt_decode, 1);
    chk("full_noenq", rename_enque, 0);
    instr(1, 2, 7, 1);
    idle(0, 0);
    chk("realloc_enq", rename_enque, 1);
    chk("realloc_map3", rename_issueinfo[17:12], 3);
    // flush recovery
    do_reset();
    instr(0, 0, 5, 1);
    instr(0, 0, 5, 1);
    idle(1, 0);
    idle(0, 1);
    instr(5, 0, 0, 0);
    chk("flush_busy", busy, {64{1'b1}});
    idle(0, 0);
    chk("flush_src_r5", rename_issueinfo[5:0], 32);
    // r0 destination and dual broadcasts
    do_reset();
    for (int k = 0; k < 10; k++) instr(0, 0, 5'(k + 1), 1);
    instr(1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 6'd40, 1, 6'd41, 0);
    chk("r0_mapwr", rename_issueinfo[17:12], 0);
    chk("r0_old", rename_old_map, 0);
    idle(0, 0);
    chk("dual_bcast", busy[41:40], 2'b11);
    instr(0, 0, 9, 1);
    idle(0, 0);
    chk("r0_no_alloc", rename_issueinfo[17:12], 42);
    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      q.delete();
      for (int i = 1; i < 64; i++) if (!m_ready[i] && !m_free[i]) q.push_back(i);
      em = q.size() > 0 ? 6'(q[$urandom_range(q.size() - 1)]) : 6'd0;
      mm = q.size() > 0 ? 6'(q[$urandom_range(q.size() - 1)]) : 6'd0;
      step($urandom_range(9) < 8, 5'($urandom), 5'($urandom), ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom),
           $urandom_range(9) < 8, $urandom_range(9) == 0, $urandom_range(49) == 0, $urandom_range(9) == 0,
           $urandom_range(2) == 0, em, $urandom_range(2) == 0, mm, $urandom_range(9) < 5);
    end
    idle(0, 0);
`ifdef RENAME_STATS_EN
    chk("stat_stall", rename_stall_cycles, m_stall);
    chk("stat_instr", rename_instr_count, m_instr);
`else
    chk("stat_stall_off", rename_stall_cycles, 0);
    chk("stat_instr_off", rename_instr_count, 0);
`endif
    // asynchronous reset while enqueuing
    instr(1, 2, 3, 1);
    @(posedge CLK);
    #3;
    chk("pre_rst_enque", rename_enque, 1);
    dec_valid = 0;
    RESET = 0;
    #1;
    chk("arst_enque", rename_enque, 0);
    chk("arst_num", rename_instr_num, 0);
    chk("arst_info", rename_issueinfo, 0);
    chk("arst_old", rename_old_map, 0);
    chk("arst_busy", busy, {64{1'b1}});
    chk("arst_halt", halt_decode, 0);
    chk("arst_stall_cnt", rename_stall_cycles, 0);
    chk("arst_instr_cnt", rename_instr_count, 0);
    mreset();
    @(negedge CLK);
    RESET = 1;
    instr(4, 5, 6, 1);
    idle(0, 0);
    chk("post_rst_num", rename_instr_num, 1);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
